predecode_fifo: RTL
===================

Name: predecode_fifo

Overview:
- Parametrised instruction buffer between fetch (IF) and decode (ID) in the MIPS pipeline.
- Decodes each instruction on enqueue and stores the result with the instruction and its PC.
- ID therefore receives a registered instruction ID, class flags and a reserved-instruction (RI) flag with no decode logic on its critical path.
- Valid/ready handshakes on both sides; flush input for branch redirect and exception entry.

Parameters:
- DEPTH, 4, number of entries; legal range 2..16, any integer in that range.
- PC_W, 32, width of the stored PC.
- TYPE_W, 6, width of the encoded instruction-ID field; must hold INST_ERR.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard all entries and the current input this cycle
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  buffer accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  ID consumes head this cycle
- out_instr  out  32  head instruction word
- out_pc  out  PC_W  head PC
- out_type  out  TYPE_W  encoded instruction ID (package constants)
- out_cls  out  5  {is_branch, is_jump, is_load, is_store, is_md}
- out_ri  out  1  head instruction is unrecognised
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (asynchronous, active-high):
  - rd_ptr = wr_ptr = count = 0; out_valid = 0; in_ready = 1.
  - Storage contents are don't-care; out_instr, out_pc, out_type, out_cls and out_ri are driven from the head entry and are don't-care while out_valid = 0.
  - Reset mid-transfer drops everything; no partial entry survives.
- Handshake rules:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != DEPTH). It is not combinationally relieved by a same-cycle pop.
  - out_valid = (count != 0).
- Occupancy and pointers:
  - Both pointers wrap from DEPTH-1 to 0; no power-of-two requirement.
  - count: +1 on push only, -1 on pop only, unchanged on push+pop.
- Full: pushes are blocked; pop proceeds normally.
- Empty: a push lands in storage; out_valid rises the next cycle, so enqueue-to-head latency is 1 cycle.
- Flush: highest priority. Next state is count = 0 with both pointers at 0, regardless of push/pop in the same cycle. The input offered that cycle is discarded, and the producer must not count it as accepted.
- Decode rules (sub-module, applied at enqueue):
  - R-type means opcode == 0; dispatch on funct.
  - opcode 000001 dispatches on rt: 00000 = bltz, 00001 = bgez. Any other rt gives INST_ERR.
  - Covered set: addu, subu, add, sub, and, or, xor, nor, sll, sllv, srl, srlv, sra, srav, slt, sltu, jr, jalr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo, ori, andi, xori, addi, addiu, slti, sltiu, lui, lw, lh, lhu, lb, lbu, sw, sh, sb, beq, bne, blez, bgtz, bltz, bgez, j, jal.
  - All-zero word decodes as sll (nop).
  - Anything else: out_type = INST_ERR, out_ri = 1, out_cls = 0.
- Class flags:
  - branch = beq/bne/blez/bgtz/bltz/bgez.
  - jump = j/jal/jr/jalr.
  - load = l*; store = s{w,h,b}.
  - md = mult/multu/div/divu/mfhi/mflo/mthi/mtlo.

Optional Feature:
- Macro: PREDECODE_BYPASS_EN.
- Defined:
  - When count == 0 and in_valid = 1, out_valid = 1 in the same cycle and the out_* fields come combinationally from the input path.
  - If out_ready is also high, the entry passes through without being written (zero latency) and count stays 0.
  - in_ready is unchanged by the bypass.
  - Flush still kills the input.
- Undefined: strict 1-cycle minimum latency as described above.

Decomposition:
- Package cpu_decode_pkg holds:
  - INST_* ID constants (0..49) and INST_ERR = 63.
  - CLS_* bit indices.
  - Opcode/funct/rt literal constants.
- Sub-module instr_classify: purely combinational; instr in; type, cls and ri out. It is instantiated once on the write path and is reused by the ID stage elsewhere.

Test Plan:
- Decode, load: push 0x00430821 (addu), then 0x8FA80004 (lw).
  - Head 1: out_type = INST_ADDU, out_cls = 0.
  - Head 2: out_type = INST_LW, out_cls = 00100.
- Decode, REGIMM and RI: push 0x04210002, 0x04000002, 0x04420002, 0xFC000000. Expected, in order:
  - INST_BGEZ, cls = 10000, ri = 0.
  - INST_BLTZ, cls = 10000, ri = 0.
  - INST_ERR, ri = 1.
  - INST_ERR, ri = 1.
- Fill/drain, DEPTH = 4, out_ready = 0:
  - 5 pushes attempted: count = 4 and in_ready = 0 after the 4th; the 5th is held by the producer.
  - Raise out_ready: pops follow FIFO PC order 0x3000, 0x3004, 0x3008, 0x300C, then the held 0x3010.
- Simultaneous push+pop at count = 2 over 10 cycles: count stays 2, order preserved, pointers wrap past 3 cleanly.
- Flush with count = 3 and in_valid = 1: next cycle count = 0 and out_valid = 0; the flushed input never appears at the head.
- Reset asserted mid-stream between clock edges: outputs drop immediately (count = 0, out_valid = 0). Under PREDECODE_BYPASS_EN, push 0x3C011234 into an empty buffer with out_ready = 1: out_type = INST_LUI in the same cycle and count stays 0.

Source files
------------

// File: rtl/cpu_decode_pkg.sv
// Shared MIPS decode vocabulary: instruction IDs, class-flag bit positions and
// the opcode/funct/rt literals used by the predecoder and the ID stage.
package cpu_decode_pkg;

    localparam int INST_W = 6;
    localparam int CLS_W  = 5;

    typedef logic [INST_W-1:0] inst_id_t;

    localparam inst_id_t INST_ADDU = 6'd0,  INST_SUBU = 6'd1,  INST_ADD  = 6'd2,  INST_SUB   = 6'd3,
                         INST_AND  = 6'd4,  INST_OR   = 6'd5,  INST_XOR  = 6'd6,  INST_NOR   = 6'd7,
                         INST_SLL  = 6'd8,  INST_SLLV = 6'd9,  INST_SRL  = 6'd10, INST_SRLV  = 6'd11,
                         INST_SRA  = 6'd12, INST_SRAV = 6'd13, INST_SLT  = 6'd14, INST_SLTU  = 6'd15,
                         INST_JR   = 6'd16, INST_JALR = 6'd17, INST_MULT = 6'd18, INST_MULTU = 6'd19,
                         INST_DIV  = 6'd20, INST_DIVU = 6'd21, INST_MFHI = 6'd22, INST_MFLO  = 6'd23,
                         INST_MTHI = 6'd24, INST_MTLO = 6'd25, INST_ORI  = 6'd26, INST_ANDI  = 6'd27,
                         INST_XORI = 6'd28, INST_ADDI = 6'd29, INST_ADDIU = 6'd30, INST_SLTI = 6'd31,
                         INST_SLTIU = 6'd32, INST_LUI = 6'd33, INST_LW   = 6'd34, INST_LH    = 6'd35,
                         INST_LHU  = 6'd36, INST_LB   = 6'd37, INST_LBU  = 6'd38, INST_SW    = 6'd39,
                         INST_SH   = 6'd40, INST_SB   = 6'd41, INST_BEQ  = 6'd42, INST_BNE   = 6'd43,
                         INST_BLEZ = 6'd44, INST_BGTZ = 6'd45, INST_BLTZ = 6'd46, INST_BGEZ  = 6'd47,
                         INST_J    = 6'd48, INST_JAL  = 6'd49, INST_ERR  = 6'd63;

    localparam int CLS_MD = 0, CLS_STORE = 1, CLS_LOAD = 2, CLS_JUMP = 3, CLS_BRANCH = 4;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
                           OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
                           OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
                           OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24,
                           OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
                           FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09,
                           FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13,
                           FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU = 6'h1B,
                           FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
                           FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
                           FN_SLT  = 6'h2A, FN_SLTU  = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;

    typedef struct packed {
        inst_id_t          id;
        logic [CLS_W-1:0]  cls;
        logic              ri;
    } decode_t;

endpackage

// File: rtl/instr_classify.sv
// Purely combinational MIPS instruction classifier: instruction word in,
// instruction ID, class flags and reserved-instruction flag out.
module instr_classify
    import cpu_decode_pkg::*;
(
    input  logic [31:0]       instr,
    output logic [INST_W-1:0] inst_type,
    output logic [CLS_W-1:0]  cls,
    output logic              ri
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];

    always_comb begin
        inst_type = INST_ERR;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU:  inst_type = INST_ADDU;
                    FN_SUBU:  inst_type = INST_SUBU;
                    FN_ADD:   inst_type = INST_ADD;
                    FN_SUB:   inst_type = INST_SUB;
                    FN_AND:   inst_type = INST_AND;
                    FN_OR:    inst_type = INST_OR;
                    FN_XOR:   inst_type = INST_XOR;
                    FN_NOR:   inst_type = INST_NOR;
                    FN_SLL:   inst_type = INST_SLL;
                    FN_SLLV:  inst_type = INST_SLLV;
                    FN_SRL:   inst_type = INST_SRL;
                    FN_SRLV:  inst_type = INST_SRLV;
                    FN_SRA:   inst_type = INST_SRA;
                    FN_SRAV:  inst_type = INST_SRAV;
                    FN_SLT:   inst_type = INST_SLT;
                    FN_SLTU:  inst_type = INST_SLTU;
                    FN_JR:    inst_type = INST_JR;
                    FN_JALR:  inst_type = INST_JALR;
                    FN_MULT:  inst_type = INST_MULT;
                    FN_MULTU: inst_type = INST_MULTU;
                    FN_DIV:   inst_type = INST_DIV;
                    FN_DIVU:  inst_type = INST_DIVU;
                    FN_MFHI:  inst_type = INST_MFHI;
                    FN_MFLO:  inst_type = INST_MFLO;
                    FN_MTHI:  inst_type = INST_MTHI;
                    FN_MTLO:  inst_type = INST_MTLO;
                    default:  inst_type = INST_ERR;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ: inst_type = INST_BLTZ;
                    RT_BGEZ: inst_type = INST_BGEZ;
                    default: inst_type = INST_ERR;
                endcase
            end
            OP_J:     inst_type = INST_J;
            OP_JAL:   inst_type = INST_JAL;
            OP_BEQ:   inst_type = INST_BEQ;
            OP_BNE:   inst_type = INST_BNE;
            OP_BLEZ:  inst_type = INST_BLEZ;
            OP_BGTZ:  inst_type = INST_BGTZ;
            OP_ADDI:  inst_type = INST_ADDI;
            OP_ADDIU: inst_type = INST_ADDIU;
            OP_SLTI:  inst_type = INST_SLTI;
            OP_SLTIU: inst_type = INST_SLTIU;
            OP_ANDI:  inst_type = INST_ANDI;
            OP_ORI:   inst_type = INST_ORI;
            OP_XORI:  inst_type = INST_XORI;
            OP_LUI:   inst_type = INST_LUI;
            OP_LB:    inst_type = INST_LB;
            OP_LH:    inst_type = INST_LH;
            OP_LW:    inst_type = INST_LW;
            OP_LBU:   inst_type = INST_LBU;
            OP_LHU:   inst_type = INST_LHU;
            OP_SB:    inst_type = INST_SB;
            OP_SH:    inst_type = INST_SH;
            OP_SW:    inst_type = INST_SW;
            default:  inst_type = INST_ERR;
        endcase
    end

    // Class flags follow from the resolved ID, so INST_ERR naturally yields zero.
    always_comb begin
        cls = '0;
        case (inst_type)
            INST_BEQ, INST_BNE, INST_BLEZ, INST_BGTZ, INST_BLTZ, INST_BGEZ:
                cls[CLS_BRANCH] = 1'b1;
            INST_J, INST_JAL, INST_JR, INST_JALR:
                cls[CLS_JUMP] = 1'b1;
            INST_LW, INST_LH, INST_LHU, INST_LB, INST_LBU:
                cls[CLS_LOAD] = 1'b1;
            INST_SW, INST_SH, INST_SB:
                cls[CLS_STORE] = 1'b1;
            INST_MULT, INST_MULTU, INST_DIV, INST_DIVU, INST_MFHI, INST_MFLO, INST_MTHI, INST_MTLO:
                cls[CLS_MD] = 1'b1;
            default: cls = '0;
        endcase
    end

    assign ri = (inst_type == INST_ERR);

endmodule

// File: rtl/predecode_fifo.sv
// IF->ID instruction buffer that decodes on enqueue and stores decode results with each entry.
// Define PREDECODE_BYPASS_EN for zero-latency pass-through while the buffer is empty.
module predecode_fifo
    import cpu_decode_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int TYPE_W = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [TYPE_W-1:0]          out_type,
    output logic [CLS_W-1:0]           out_cls,
    output logic                       out_ri,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      instr_d [DEPTH];
    logic [PC_W-1:0]  pc_q    [DEPTH];
    logic [PC_W-1:0]  pc_d    [DEPTH];
    decode_t          dec_q   [DEPTH];
    decode_t          dec_d   [DEPTH];

    decode_t dec_in;
    logic    bypass_hit, push, pop, wr_en, rd_en;

    instr_classify u_classify (
        .instr     (in_instr),
        .inst_type (dec_in.id),
        .cls       (dec_in.cls),
        .ri        (dec_in.ri)
    );

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A bypassed entry that is consumed in the same cycle is never written.
    always_comb begin
        bypass_hit = 1'b0;
`ifdef PREDECODE_BYPASS_EN
        bypass_hit = (count_q == '0) && in_valid && !flush;
`endif
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != '0) || bypass_hit;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wr_en     = push && !flush && !(bypass_hit && out_ready);
        rd_en     = pop && !flush && !bypass_hit;

        instr_d  = instr_q;
        pc_d     = pc_q;
        dec_d    = dec_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            instr_d[wr_ptr_q] = in_instr;
            pc_d[wr_ptr_q]    = in_pc;
            dec_d[wr_ptr_q]   = dec_in;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
            if (rd_en) rd_ptr_d = next_ptr(rd_ptr_q);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        out_instr = instr_q[rd_ptr_q];
        out_pc    = pc_q[rd_ptr_q];
        out_type  = TYPE_W'(dec_q[rd_ptr_q].id);
        out_cls   = dec_q[rd_ptr_q].cls;
        out_ri    = dec_q[rd_ptr_q].ri;
        if (bypass_hit) begin
            out_instr = in_instr;
            out_pc    = in_pc;
            out_type  = TYPE_W'(dec_in.id);
            out_cls   = dec_in.cls;
            out_ri    = dec_in.ri;
        end
    end

    assign count = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
        dec_q   <= dec_d;
    end

endmodule
